ring_counter_gen: RTL and testbench

//  Parametrised successor to the fixed 16-bit ring counter: WIDTH-bit shift counter with run-time

---
 rtl/ring_pkg.sv | 8 +
 rtl/ring_counter_gen_if.sv | 16 +
 rtl/shift_step_counter.sv | 39 +++
 rtl/ring_counter_gen.sv | 57 +++++
 tb/tb_ring_counter_gen.sv | 137 +++++++++++++
 5 files changed

// File: rtl/ring_pkg.sv
// ring_pkg: shared mode and direction encodings for the ring/Johnson shift counter
package ring_pkg;
    localparam logic [1:0] MODE_RING    = 2'b00;
    localparam logic [1:0] MODE_JOHNSON = 2'b01;
    localparam logic [1:0] MODE_HOLD    = 2'b10;
    localparam logic       DIR_LSB      = 1'b0;
    localparam logic       DIR_MSB      = 1'b1;
endpackage

// File: rtl/ring_counter_gen_if.sv
// ring_counter_gen_if: control inputs and counter outputs of the ring counter generator
interface ring_counter_gen_if #(
    parameter int WIDTH = 16,
    parameter int SW    = $clog2(2 * WIDTH)
);
    logic             Ld;
    logic             En;
    logic [WIDTH-1:0] In;
    logic [1:0]       Mode;
    logic             Dir;
    logic [WIDTH-1:0] Out;
    logic [SW-1:0]    Step;
    logic             Wrap;
    modport master (output Ld, En, In, Mode, Dir, input Out, Step, Wrap);
    modport slave  (input Ld, En, In, Mode, Dir, output Out, Step, Wrap);
endinterface

// File: rtl/shift_step_counter.sv
// shift_step_counter: modulo-period shift counter with a one-cycle pulse after the last shift of a period
module shift_step_counter #(
    parameter int SW = 5
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          ld,
    input  logic          adv,
    input  logic [SW:0]   period,
    output logic [SW-1:0] step,
    output logic          wrap
);
    logic [SW-1:0] step_q, step_d;
    logic          wrap_q, wrap_d;
    logic          last;
    // next step: restart on load, roll over at period end and flag it
    always_comb begin
        step_d = step_q;
        wrap_d = 1'b0;
        last   = ({1'b0, step_q} == period - 1'b1);
        if (ld) step_d = '0;
        else if (adv) begin
            step_d = last ? '0 : step_q + 1'b1;
            wrap_d = last;
        end
    end
    // step and wrap registers
    always_ff @(posedge clk) begin
        if (clr) begin
            step_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            step_q <= step_d;
            wrap_q <= wrap_d;
        end
    end
    assign step = step_q;
    assign wrap = wrap_q;
endmodule

// File: rtl/ring_counter_gen.sv
// ring_counter_gen: WIDTH-bit ring/Johnson shift counter with load, enable, step count and wrap pulse
module ring_counter_gen
    import ring_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input logic         Clk,
    input logic         Clr,
    ring_counter_gen_if.slave bus
);
    localparam int SW = $clog2(2 * WIDTH);
    logic [WIDTH-1:0] out_q, out_d;
    logic [1:0]       mode_q, mode_d;
    logic             dir_q, dir_d;
    logic             fb;
    logic             adv;
    logic [SW:0]      period;
    // next state: load takes config and pattern, otherwise shift when enabled and not holding
    always_comb begin
        out_d  = out_q;
        mode_d = mode_q;
        dir_d  = dir_q;
        adv    = bus.En && !mode_q[1];
        fb     = (dir_q == DIR_MSB ? out_q[WIDTH-1] : out_q[0]) ^ (mode_q == MODE_JOHNSON);
        period = mode_q == MODE_JOHNSON ? (SW+1)'(2 * WIDTH) : (SW+1)'(WIDTH);
        if (bus.Ld) begin
            out_d  = bus.In;
            mode_d = bus.Mode;
            dir_d  = bus.Dir;
        end else if (adv) begin
            out_d = dir_q == DIR_MSB ? {out_q[WIDTH-2:0], fb} : {fb, out_q[WIDTH-1:1]};
        end
    end
    // pattern and configuration registers
    always_ff @(posedge Clk) begin
        if (Clr) begin
            out_q  <= RESET_VAL;
            mode_q <= MODE_RING;
            dir_q  <= DIR_LSB;
        end else begin
            out_q  <= out_d;
            mode_q <= mode_d;
            dir_q  <= dir_d;
        end
    end
    shift_step_counter #(.SW(SW)) u_step (
        .clk    (Clk),
        .clr    (Clr),
        .ld     (bus.Ld),
        .adv    (adv),
        .period (period),
        .step   (bus.Step),
        .wrap   (bus.Wrap)
    );
    assign bus.Out = out_q;
endmodule

// File: tb/tb_ring_counter_gen.sv
// tb_ring_counter_gen: directed and random checks of ring_counter_gen against a behavioural model
module tb_ring_counter_gen;
    logic clk;
    logic clr;
    int   vectors;
    int   fails;
    logic [7:0] m_out;
    logic [1:0] m_mode;
    logic       m_dir;
    int         m_cnt;
    logic       m_wrap;
    logic [7:0] seq2 [8]  = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    logic [7:0] seq3 [16] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                              8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
    ring_counter_gen_if #(.WIDTH(8)) rif ();
    ring_counter_gen #(.WIDTH(8), .RESET_VAL(8'h01)) dut (
        .Clk (clk),
        .Clr (clr),
        .bus (rif)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    // behavioural reference: rotation by arithmetic, step as a plain shift count within the period
    task automatic model();
        int p;
        if (clr) begin
            m_out = 8'h01; m_mode = 2'b00; m_dir = 1'b0; m_cnt = 0; m_wrap = 1'b0;
        end else if (rif.Ld) begin
            m_out = rif.In; m_mode = rif.Mode; m_dir = rif.Dir; m_cnt = 0; m_wrap = 1'b0;
        end else if (rif.En && m_mode < 2) begin
            p = (m_mode == 1) ? 16 : 8;
            if (m_mode == 0)
                m_out = m_dir ? 8'((m_out << 1) | (m_out >> 7)) : 8'((m_out >> 1) | (m_out << 7));
            else
                m_out = m_dir ? 8'((m_out << 1) | ((~m_out >> 7) & 8'h01))
                              : 8'((m_out >> 1) | ((~m_out & 8'h01) << 7));
            m_cnt++;
            m_wrap = (m_cnt == p);
            if (m_wrap) m_cnt = 0;
        end else m_wrap = 1'b0;
    endtask
    task automatic tick(input string tag);
        @(posedge clk);
        model();
        #1;
        chk({tag, "_out"}, 32'(rif.Out), 32'(m_out));
        chk({tag, "_step"}, 32'(rif.Step), 32'(m_cnt));
        chk({tag, "_wrap"}, 32'(rif.Wrap), 32'(m_wrap));
    endtask
    task automatic drive(input logic c, input logic ld, input logic en, input logic [7:0] din,
                         input logic [1:0] mode, input logic dir);
        clr = c; rif.Ld = ld; rif.En = en; rif.In = din; rif.Mode = mode; rif.Dir = dir;
    endtask
    initial begin
        vectors = 0;
        fails = 0;
        m_out = '0; m_mode = '0; m_dir = 1'b0; m_cnt = 0; m_wrap = 1'b0;
        drive(1, 0, 0, 8'h00, 2'b00, 0);
        tick("rst");
        chk("rst_const_out", 32'(rif.Out), 32'h01);
        drive(1, 1, 1, 8'hAA, 2'b01, 1);
        tick("rst_ld_en");
        chk("rst_ld_en_const", 32'({rif.Out, rif.Step, rif.Wrap}), 32'({8'h01, 4'h0, 1'b0}));
        drive(0, 1, 0, 8'h01, 2'b00, 0);
        tick("ld_ring");
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 1, 8'h00, 2'b11, 1);
            tick("ring_lsb");
            chk("ring_lsb_seq", 32'(rif.Out), 32'(seq2[i]));
            chk("ring_lsb_wrap", 32'(rif.Wrap), 32'(i == 7));
        end
        chk("ring_wrap_step0", 32'(rif.Step), 32'h0);
        drive(0, 1, 0, 8'h00, 2'b01, 1);
        tick("ld_john");
        for (int i = 0; i < 16; i++) begin
            drive(0, 0, 1, 8'h00, 2'b00, 0);
            tick("john_msb");
            chk("john_msb_seq", 32'(rif.Out), 32'(seq3[i]));
            chk("john_msb_wrap", 32'(rif.Wrap), 32'(i == 15));
        end
        drive(0, 0, 1, 8'h00, 2'b00, 0);
        tick("john_after");
        chk("john_after_wrap", 32'(rif.Wrap), 32'h0);
        drive(0, 1, 0, 8'h01, 2'b00, 0);
        tick("ld_mid");
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 8'h00, 2'b00, 0);
            tick("mid_shift");
        end
        chk("mid_step3", 32'(rif.Step), 32'h3);
        drive(0, 1, 1, 8'h81, 2'b00, 0);
        tick("ld_en");
        chk("ld_en_const", 32'({rif.Out, rif.Step}), 32'({8'h81, 4'h0}));
        drive(0, 1, 0, 8'h5A, 2'b10, 0);
        tick("ld_hold");
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 8'h00, 2'b00, 1);
            tick("hold");
            chk("hold_const", 32'({rif.Out, rif.Step, rif.Wrap}), 32'({8'h5A, 4'h0, 1'b0}));
        end
        drive(0, 1, 0, 8'h03, 2'b00, 0);
        tick("ld_ring2");
        drive(0, 0, 1, 8'h00, 2'b00, 0);
        tick("ring2_sh");
        tick("ring2_sh");
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 8'h00, 2'b01, 1);
            tick("en0");
            chk("en0_const", 32'({rif.Out, rif.Step}), 32'({8'hC0, 4'h2}));
        end
        drive(0, 1, 0, 8'h80, 2'b00, 1);
        tick("ld_dir1");
        drive(0, 0, 1, 8'h00, 2'b00, 0);
        tick("dir1_a");
        chk("dir1_a_const", 32'({rif.Out, rif.Step}), 32'({8'h01, 4'h1}));
        drive(0, 0, 0, 8'h00, 2'b00, 0);
        tick("dir1_b");
        chk("dir1_b_const", 32'({rif.Out, rif.Step}), 32'({8'h01, 4'h1}));
        drive(0, 0, 1, 8'h00, 2'b00, 0);
        tick("dir1_c");
        chk("dir1_c_const", 32'({rif.Out, rif.Step}), 32'({8'h02, 4'h2}));
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 49) == 0, $urandom_range(0, 14) == 0, $urandom_range(0, 3) != 0,
                  8'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            tick("rand");
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
